// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with response queue and redirect flush; FETCH_MISALIGN_TRAP_EN adds a misaligned-target fault entry and a HALT state
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int SW = $clog2(DEPTH + MAX_OUT + 1);
  logic [31:0] pc_q, pc_d, resp_pc_q, resp_pc_d, tgt_pc;
  logic [OW-1:0] out_q, out_d, drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [31:0] inst_q [DEPTH];
  logic [31:0] ipc_q [DEPTH];
  logic halted, fault_push, grant, live_push, push, pop;
`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic {RUN, HALT} state_e;
  state_e state_q, state_d;
  logic fpend_q, fpend_d;
  logic fault_q [DEPTH];
  always_comb begin
    state_d = redirect ? (redirect_pc[1:0] != 2'b00 ? HALT : RUN) : state_q;
    fpend_d = redirect && redirect_pc[1:0] != 2'b00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fpend_q <= fpend_d;
    end
    if (push) fault_q[tail_q] <= fault_push;
  end
  assign tgt_pc      = redirect_pc;
  assign halted      = state_q == HALT;
  assign fault_push  = fpend_q;
  assign fetch_fault = inst_valid && fault_q[head_q];
`else
  assign tgt_pc      = redirect_pc & ~32'h3;
  assign halted      = 1'b0;
  assign fault_push  = 1'b0;
  assign fetch_fault = 1'b0;
`endif
  // live words = queued + outstanding not yet marked for drop; each must have a slot reserved
  assign imem_req   = !rst && !redirect && !halted && out_q < OW'(MAX_OUT) &&
                      (SW'(cnt_q) + SW'(out_q) - SW'(drop_q)) < SW'(DEPTH);
  assign imem_addr  = pc_q;
  assign grant      = imem_req && imem_gnt;
  assign live_push  = imem_rvalid && drop_q == '0;
  assign push       = !redirect && (live_push || fault_push);
  assign pop        = !redirect && inst_valid && inst_ready;
  assign inst_valid = cnt_q != '0;
  assign inst       = inst_valid ? inst_q[head_q] : '0;
  assign inst_pc    = inst_valid ? ipc_q[head_q] : '0;
  always_comb begin
    pc_d      = redirect ? tgt_pc : grant ? pc_q + 32'd4 : pc_q;
    resp_pc_d = redirect ? tgt_pc : (push && !fault_push) ? resp_pc_q + 32'd4 : resp_pc_q;
    out_d     = out_q + OW'(grant) - OW'(imem_rvalid);
    drop_d    = redirect ? out_q - OW'(imem_rvalid) :
                (imem_rvalid && drop_q != '0) ? drop_q - OW'(1) : drop_q;
    cnt_d     = redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
    head_d    = redirect ? '0 : head_q + AW'(pop);
    tail_d    = redirect ? '0 : tail_q + AW'(push);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
      cnt_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
    if (push) begin
      inst_q[tail_q] <= fault_push ? 32'h0000_0013 : imem_rdata;
      ipc_q[tail_q]  <= fault_push ? pc_q : resp_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench with a latency-randomized memory and a stream-level fetch model
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 4;
  localparam int MAX_OUT = 2;
  logic clk, rst, imem_req, imem_gnt, imem_rvalid, redirect, inst_valid, inst_ready, fetch_fault;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .fetch_fault(fetch_fault)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {logic [31:0] data; int due;} resp_t;
  typedef struct {logic [31:0] tgt; int lat; logic [31:0] pc0; logic [31:0] pc1;} vec_t;
  resp_t rq[$];
  logic [31:0] acc_q[$];
  int checks = 0, failures = 0, cyc = 0, last_due = -1, outst = 0;
  int lat_min = 1, lat_max = 1, gnt_pct = 100, first_valid_cyc = -1, rcyc = 0;
  logic [31:0] exp_pc, exp_addr, prev_inst, prev_pc;
  logic m_halt = 0, m_fault_left = 0, prev_hold = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    int l;
    logic [31:0] tgt;
    imem_rvalid = rq.size() > 0 && rq[0].due <= cyc;
    imem_rdata = imem_rvalid ? rq[0].data : 32'hDEAD_BEEF;
    if (imem_rvalid) void'(rq.pop_front());
    imem_gnt = int'($urandom_range(99)) < gnt_pct;
    #1;
    if (redirect) chk("req_in_redirect", imem_req, 0);
    if (m_halt) chk("req_while_halted", imem_req, 0);
    if (imem_req && imem_gnt) begin
      chk("req_addr", imem_addr, exp_addr);
      exp_addr += 32'd4;
      l = lat_min + int'($urandom_range(lat_max - lat_min));
      last_due = (cyc + l > last_due + 1) ? cyc + l : last_due + 1;
      rq.push_back('{word_at(imem_addr), last_due});
      outst++;
    end
    if (imem_rvalid) outst--;
    chk("outstanding_bound", outst <= MAX_OUT, 1);
    chk("words_in_flight_bound", ((exp_addr - exp_pc) >> 2) <= DEPTH, 1);
    if (prev_hold) begin
      chk("hold_valid", inst_valid, 1);
      chk("hold_inst", inst, prev_inst);
      chk("hold_pc", inst_pc, prev_pc);
    end
    if (inst_valid && inst_ready && !redirect) begin
      if (m_halt) begin
        chk("post_fault_entry", m_fault_left, 1);
        chk("fault_inst", inst, 32'h0000_0013);
        chk("fault_pc", inst_pc, exp_pc);
        chk("fault_flag_set", fetch_fault, 1);
        m_fault_left = 0;
      end else begin
        chk("inst_pc", inst_pc, exp_pc);
        chk("inst_word", inst, word_at(exp_pc));
        chk("fault_flag_clear", fetch_fault, 0);
        exp_pc += 32'd4;
      end
      acc_q.push_back(inst_pc);
    end
    if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    prev_hold = inst_valid && !inst_ready && !redirect;
    prev_inst = inst;
    prev_pc = inst_pc;
    if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      tgt = redirect_pc;
      m_halt = redirect_pc[1:0] != 2'b00;
      m_fault_left = m_halt;
`else
      tgt = redirect_pc & ~32'h3;
`endif
      exp_pc = tgt;
      exp_addr = tgt;
      acc_q.delete();
      first_valid_cyc = -1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect = 1;
    redirect_pc = t;
    rcyc = cyc;
    tick();
    redirect = 0;
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int b = budget;
    while (acc_q.size() < n && b > 0) begin
      tick();
      b--;
    end
    chk(name, acc_q.size() >= n, 1);
  endtask

  vec_t tbl[5];
  logic [31:0] saved;
  int b;
  logic found;

  initial begin
    tbl[0] = '{32'h0000_0100, 1, 32'h0000_0100, 32'h0000_0104};
    tbl[1] = '{32'h0000_0040, 2, 32'h0000_0040, 32'h0000_0044};
    tbl[2] = '{32'h0000_1000, 3, 32'h0000_1000, 32'h0000_1004};
    tbl[3] = '{32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0000_0000};
`ifdef FETCH_MISALIGN_TRAP_EN
    tbl[4] = '{32'h0000_0300, 2, 32'h0000_0300, 32'h0000_0304};
`else
    tbl[4] = '{32'h0000_0102, 1, 32'h0000_0100, 32'h0000_0104};
`endif
    rst = 1; redirect = 0; redirect_pc = 0; inst_ready = 1;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_fault", fetch_fault, 0);
    @(negedge clk);
    rst = 0;
    exp_pc = RESET_PC;
    exp_addr = RESET_PC;
    #1;
    chk("first_req_after_rst", imem_req, 1);
    repeat (10) tick();
    chk("first_valid_cycle", first_valid_cyc, 2);
    if (acc_q.size() >= 3) begin
      chk("stream_pc0", acc_q[0], 32'h0);
      chk("stream_pc1", acc_q[1], 32'h4);
      chk("stream_pc2", acc_q[2], 32'h8);
    end else chk("stream_count", acc_q.size(), 3);

    inst_ready = 0;
    repeat (20) tick();
    #1;
    chk("bp_req_dropped", imem_req, 0);
    chk("bp_valid", inst_valid, 1);
    chk("bp_words_held", (exp_addr - exp_pc) >> 2, DEPTH);
    saved = exp_pc;
    acc_q.delete();
    inst_ready = 1;
    repeat (10) tick();
    if (acc_q.size() >= 1) chk("bp_drain_head", acc_q[0], saved);
    chk("bp_drain_count", acc_q.size() >= DEPTH, 1);

    for (int i = 0; i < 5; i++) begin
      lat_min = tbl[i].lat;
      lat_max = tbl[i].lat;
      gnt_pct = 0;
      repeat (8) tick();
      gnt_pct = 100;
      do_redirect(tbl[i].tgt);
      run_until(2, 40, "tbl_timeout");
      chk("tbl_latency", first_valid_cyc, rcyc + 2 + tbl[i].lat);
      if (acc_q.size() >= 2) begin
        chk("tbl_pc0", acc_q[0], tbl[i].pc0);
        chk("tbl_pc1", acc_q[1], tbl[i].pc1);
      end
    end

    lat_min = 3; lat_max = 3;
    b = 30;
    while (!(outst == 2 && !(rq.size() > 0 && rq[0].due <= cyc)) && b > 0) begin
      tick();
      b--;
    end
    chk("inflight_setup", outst, 2);
    do_redirect(32'h0000_0100);
    run_until(1, 40, "inflight_timeout");
    if (acc_q.size() >= 1) chk("inflight_first_pc", acc_q[0], 32'h0000_0100);

    lat_min = 1; lat_max = 1;
    found = 0;
    b = 30;
    while (!found && b > 0) begin
      found = rq.size() > 0 && rq[0].due <= cyc && inst_valid;
      if (!found) tick();
      b--;
    end
    chk("coincident_setup", found, 1);
    do_redirect(32'h0000_0200);
    run_until(2, 40, "coincident_timeout");
    if (acc_q.size() >= 2) begin
      chk("coincident_pc0", acc_q[0], 32'h0000_0200);
      chk("coincident_pc1", acc_q[1], 32'h0000_0204);
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    do_redirect(32'h0000_0102);
    repeat (12) tick();
    chk("misalign_entries", acc_q.size(), 1);
    if (acc_q.size() >= 1) chk("misalign_pc", acc_q[0], 32'h0000_0102);
    do_redirect(32'h0000_0200);
    run_until(2, 40, "resume_timeout");
    if (acc_q.size() >= 2) chk("resume_pc1", acc_q[1], 32'h0000_0204);
`endif

    lat_min = 1; lat_max = 4; gnt_pct = 75;
    for (int i = 0; i < 3000; i++) begin
      inst_ready = $urandom_range(99) < 70;
      if ($urandom_range(99) < 4) begin
        redirect = 1;
        redirect_pc = ($urandom_range(7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      end else redirect = 0;
      tick();
    end
    redirect = 0;
    inst_ready = 1;
    repeat (20) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
